// File: rtl/m68k_bus_pkg.sv
// Shared state encoding, request bundle and strobe constants
// for the 68000-style bus master.
package m68k_bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_S0,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_S4,
        ST_S5,
        ST_S6,
        ST_S7,
        ST_W
    } bus_state_e;

    localparam logic STB_OFF = 1'b1;
    localparam logic STB_ON = 1'b0;
    localparam logic RW_READ = 1'b1;
    localparam logic [15:0] BERR_FILL = 16'hFFFF;

    typedef struct packed {
        logic [22:0] addr;
        logic        rw;
        logic        uds;
        logic        lds;
        logic [15:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/m68k_bus_master_if.sv
// Requester handshake plus 68000 bus pins, seen from the master
// (the sequencer) and the slave (requester and bus decode).
interface m68k_bus_master_if;

    logic        req;
    logic        req_rw;
    logic [22:0] req_addr;
    logic        req_uds;
    logic        req_lds;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        done;
    logic        berr;
    logic [15:0] rdata;
    logic [22:0] VA;
    logic        AS;
    logic        UDS;
    logic        LDS;
    logic        RW;
    logic [15:0] VD_o;
    logic        VD_oe;
    logic [15:0] VD_i;
    logic        DTACK;

    modport master (
        input  req, req_rw, req_addr, req_uds, req_lds, req_wdata,
        input  VD_i, DTACK,
        output req_ready, done, berr, rdata,
        output VA, AS, UDS, LDS, RW, VD_o, VD_oe
    );

    modport slave (
        output req, req_rw, req_addr, req_uds, req_lds, req_wdata,
        output VD_i, DTACK,
        input  req_ready, done, berr, rdata,
        input  VA, AS, UDS, LDS, RW, VD_o, VD_oe
    );

endinterface

// File: rtl/bus_tick_gen.sv
// Free-running MCLK divider; tick_o marks the last count of each
// bus state period.
module bus_tick_gen #(
    parameter int TICK_DIV = 2
) (
    input  logic MCLK,
    input  logic RES_n,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);
    assign cnt_d = tick_o ? '0 : cnt_q + 1'b1;

    always_ff @(posedge MCLK or negedge RES_n) begin
        if (!RES_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/m68k_bus_master.sv
// Runs one 68000 bus cycle (S0-S7 plus wait pairs) per accepted
// request; all bus pins and requester outputs are registered.
module m68k_bus_master
    import m68k_bus_pkg::*;
#(
    parameter int TICK_DIV = 2,
    parameter int TIMEOUT  = 128
) (
    input  logic MCLK,
    input  logic RES_n,
    m68k_bus_master_if.master bus
);

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WLAST = WCW'(TIMEOUT - 1);

    logic           tick;
    bus_state_e     state_q;
    bus_req_t       req_q;
    logic [WCW-1:0] wcnt_q;
    logic           wph_q;
    logic           berr_pend_q;
    logic           dtk1_q, dtk2_q;
    logic           as_q, uds_q, lds_q, rw_q;
    logic [15:0]    vd_q;
    logic           oe_q;
    logic           done_q, berr_q, ready_q;
    logic [15:0]    rdata_q;

    bus_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .MCLK  (MCLK),
        .RES_n (RES_n),
        .tick_o(tick)
    );

    always_ff @(posedge MCLK or negedge RES_n) begin
        if (!RES_n) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            wcnt_q      <= '0;
            wph_q       <= 1'b0;
            berr_pend_q <= 1'b0;
            dtk1_q      <= 1'b1;
            dtk2_q      <= 1'b1;
            as_q        <= STB_OFF;
            uds_q       <= STB_OFF;
            lds_q       <= STB_OFF;
            rw_q        <= RW_READ;
            vd_q        <= '0;
            oe_q        <= 1'b0;
            done_q      <= 1'b0;
            berr_q      <= 1'b0;
            ready_q     <= 1'b1;
            rdata_q     <= '0;
        end else begin
            dtk1_q <= bus.DTACK;
            dtk2_q <= dtk1_q;
            done_q <= 1'b0;
            if (state_q == ST_IDLE && done_q) begin
                ready_q <= 1'b1;
            end
            if (tick) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (bus.req && ready_q) begin
                            req_q       <= '{addr: bus.req_addr,
                                             rw: bus.req_rw,
                                             uds: bus.req_uds,
                                             lds: bus.req_lds,
                                             wdata: bus.req_wdata};
                            rw_q        <= bus.req_rw;
                            ready_q     <= 1'b0;
                            wcnt_q      <= '0;
                            wph_q       <= 1'b0;
                            berr_pend_q <= 1'b0;
                            state_q     <= ST_S0;
                        end
                    end
                    ST_S0: state_q <= ST_S1;
                    ST_S1: begin
                        as_q <= STB_ON;
                        if (req_q.rw) begin
                            uds_q <= ~req_q.uds;
                            lds_q <= ~req_q.lds;
                        end
                        state_q <= ST_S2;
                    end
                    ST_S2: begin
                        if (!req_q.rw) begin
                            vd_q <= req_q.wdata;
                            oe_q <= 1'b1;
                        end
                        state_q <= ST_S3;
                    end
                    ST_S3: begin
                        if (!req_q.rw) begin
                            uds_q <= ~req_q.uds;
                            lds_q <= ~req_q.lds;
                        end
                        state_q <= ST_S4;
                    end
                    ST_S4: begin
                        state_q <= dtk2_q ? ST_W : ST_S5;
                    end
                    // Second half of each wait pair resamples DTACK
                    ST_W: begin
                        wph_q <= ~wph_q;
                        if (wph_q) begin
                            if (!dtk2_q) begin
                                state_q <= ST_S5;
                            end else if (wcnt_q == WLAST) begin
                                berr_pend_q <= 1'b1;
                                state_q     <= ST_S5;
                            end else begin
                                wcnt_q <= wcnt_q + 1'b1;
                            end
                        end
                    end
                    ST_S5: state_q <= ST_S6;
                    ST_S6: begin
                        if (req_q.rw) begin
                            rdata_q <= berr_pend_q ? BERR_FILL : bus.VD_i;
                        end
                        as_q    <= STB_OFF;
                        uds_q   <= STB_OFF;
                        lds_q   <= STB_OFF;
                        state_q <= ST_S7;
                    end
                    ST_S7: begin
                        done_q  <= 1'b1;
                        berr_q  <= berr_pend_q;
                        oe_q    <= 1'b0;
                        rw_q    <= RW_READ;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.done      = done_q;
    assign bus.berr      = berr_q;
    assign bus.rdata     = rdata_q;
    assign bus.VA        = req_q.addr;
    assign bus.AS        = as_q;
    assign bus.UDS       = uds_q;
    assign bus.LDS       = lds_q;
    assign bus.RW        = rw_q;
    assign bus.VD_o      = vd_q;
    assign bus.VD_oe     = oe_q;

endmodule

// File: tb/tb_m68k_bus_master.sv
// Directed bench for m68k_bus_master: writes, reads, wait states,
// timeout, mid-cycle reset and back-to-back requests.
module tb_m68k_bus_master;

    logic MCLK = 1'b0;
    logic RES_n = 1'b0;

    m68k_bus_master_if bus();

    m68k_bus_master #(.TICK_DIV(2), .TIMEOUT(4)) dut (
        .MCLK (MCLK),
        .RES_n(RES_n),
        .bus  (bus)
    );

    always #5 MCLK = ~MCLK;

    int n_run = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    int lat = 0;
    int d1 = 0;
    int ndone = 0;
    logic [63:0] as_m, uds_m, lds_m, oe_m, rwl_m, rdy_m;
    logic tm0 = 1'b0;
    logic tm1 = 1'b0;
    logic tmss_rel;

    always @(posedge MCLK) cyc <= cyc + 1;

    // Minimal TMSS unlock: both 'SEGA' words written with full strobes
    always @(posedge MCLK) begin
        if (!bus.AS && !bus.RW && !bus.UDS && !bus.LDS) begin
            if (bus.VA == 23'h50A000 && bus.VD_o == 16'h5345) tm0 <= 1'b1;
            if (bus.VA == 23'h50A001 && bus.VD_o == 16'h4741) tm1 <= 1'b1;
        end
    end
    assign tmss_rel = tm0 & tm1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_req(input logic rw, input logic [22:0] a,
                             input logic u, input logic l,
                             input logic [15:0] wd, input bit hold);
        bit acc = 0;
        bus.req_rw    = rw;
        bus.req_addr  = a;
        bus.req_uds   = u;
        bus.req_lds   = l;
        bus.req_wdata = wd;
        bus.req       = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge MCLK);
            if (!bus.req_ready) begin
                acc = 1;
                break;
            end
        end
        t0 = cyc;
        if (!hold) bus.req = 1'b0;
        chk("accept", 64'(acc), 64'd1);
    endtask

    task automatic finish_req(input int rel);
        int o;
        bit seen = 0;
        as_m = '0; uds_m = '0; lds_m = '0;
        oe_m = '0; rwl_m = '0; rdy_m = '0;
        for (int k = 0; k < 100; k++) begin
            o = cyc - t0;
            if (o == rel) bus.DTACK = 1'b0;
            if (o >= 0 && o < 64) begin
                as_m[o]  = ~bus.AS;
                uds_m[o] = ~bus.UDS;
                lds_m[o] = ~bus.LDS;
                oe_m[o]  = bus.VD_oe;
                rwl_m[o] = ~bus.RW;
                rdy_m[o] = bus.req_ready;
            end
            if (bus.done) begin
                seen = 1;
                lat = o;
                break;
            end
            @(negedge MCLK);
        end
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.req = 1'b0;
        bus.req_rw = 1'b1;
        bus.req_addr = '0;
        bus.req_uds = 1'b0;
        bus.req_lds = 1'b0;
        bus.req_wdata = '0;
        bus.VD_i = '0;
        bus.DTACK = 1'b0;
        repeat (3) @(negedge MCLK);
        chk("rst_strb", 64'({bus.AS, bus.UDS, bus.LDS, bus.RW}), 64'hF);
        chk("rst_va", 64'(bus.VA), 64'h0);
        chk("rst_vd", 64'({bus.VD_o, bus.VD_oe}), 64'h0);
        chk("rst_req", 64'({bus.done, bus.berr, bus.rdata, bus.req_ready}),
            64'h1);
        RES_n = 1'b1;
        @(negedge MCLK);

        // TMSS unlock writes
        start_req(1'b0, 23'h50A000, 1'b1, 1'b1, 16'h5345, 1'b0);
        finish_req(-1);
        chk("w1_lat", 64'(lat), 64'd16);
        chk("w1_berr", 64'(bus.berr), 64'd0);
        chk("w1_uds", uds_m, 64'h3F00);
        chk("w1_lds", lds_m, 64'h3F00);
        chk("w1_as", as_m, 64'h3FF0);
        chk("w1_oe", oe_m, 64'hFFC0);
        chk("w1_rw", rwl_m, 64'hFFFF);
        chk("w1_va", 64'(bus.VA), 64'h50A000);
        chk("w1_vd", 64'(bus.VD_o), 64'h5345);
        chk("w1_rdata", 64'(bus.rdata), 64'h0);
        @(negedge MCLK);
        chk("w1_pulse", 64'(bus.done), 64'd0);
        chk("tmss_lock", 64'(tmss_rel), 64'd0);
        start_req(1'b0, 23'h50A001, 1'b1, 1'b1, 16'h4741, 1'b0);
        finish_req(-1);
        chk("w2_lat", 64'(lat), 64'd16);
        chk("w2_berr", 64'(bus.berr), 64'd0);
        chk("w2_uds", uds_m, 64'h3F00);
        chk("tmss_rel", 64'(tmss_rel), 64'd1);

        // Zero-wait read
        bus.VD_i = 16'h1234;
        start_req(1'b1, 23'h000100, 1'b1, 1'b1, 16'h0, 1'b0);
        finish_req(-1);
        chk("rd_lat", 64'(lat), 64'd16);
        chk("rd_data", 64'(bus.rdata), 64'h1234);
        chk("rd_berr", 64'(bus.berr), 64'd0);
        chk("rd_oe", oe_m, 64'h0);
        chk("rd_uds", uds_m, 64'h3FF0);
        chk("rd_rw", rwl_m, 64'h0);

        // Three wait pairs, upper lane only
        bus.DTACK = 1'b1;
        bus.VD_i = 16'hCAFE;
        start_req(1'b1, 23'h000102, 1'b1, 1'b0, 16'h0, 1'b0);
        finish_req(19);
        chk("ws_lat", 64'(lat), 64'd28);
        chk("ws_berr", 64'(bus.berr), 64'd0);
        chk("ws_as", as_m, 64'h03FF_FFF0);
        chk("ws_uds", uds_m, 64'h03FF_FFF0);
        chk("ws_lds", lds_m, 64'h0);
        chk("ws_data", 64'(bus.rdata), 64'hCAFE);

        // Timeout
        bus.DTACK = 1'b1;
        bus.VD_i = 16'hBEEF;
        start_req(1'b1, 23'h000104, 1'b1, 1'b1, 16'h0, 1'b0);
        finish_req(-1);
        chk("to_lat", 64'(lat), 64'd32);
        chk("to_berr", 64'(bus.berr), 64'd1);
        chk("to_data", 64'(bus.rdata), 64'hFFFF);
        chk("to_as", as_m, 64'h3FFF_FFF0);
        bus.DTACK = 1'b0;
        repeat (3) @(negedge MCLK);

        // Reset during S4 of a write
        start_req(1'b0, 23'h000300, 1'b1, 1'b1, 16'hA5A5, 1'b0);
        for (int i = 0; i < 20 && (cyc - t0) < 9; i++) @(negedge MCLK);
        chk("rst_pre_uds", 64'(bus.UDS), 64'd0);
        RES_n = 1'b0;
        #1;
        chk("rst_mid", 64'({bus.AS, bus.UDS, bus.LDS, bus.VD_oe}), 64'hE);
        @(negedge MCLK);
        RES_n = 1'b1;
        @(negedge MCLK);
        chk("rst_ready", 64'(bus.req_ready), 64'd1);
        ndone = 0;
        repeat (40) begin
            @(negedge MCLK);
            if (bus.done) ndone++;
        end
        chk("rst_nodone", 64'(ndone), 64'd0);

        // Back-to-back with req held high
        bus.VD_i = 16'h0BB0;
        start_req(1'b1, 23'h000200, 1'b1, 1'b1, 16'h0, 1'b1);
        finish_req(-1);
        d1 = cyc;
        chk("bb1_lat", 64'(lat), 64'd16);
        chk("bb1_rdy", rdy_m, 64'h0);
        start_req(1'b1, 23'h000200, 1'b1, 1'b1, 16'h0, 1'b1);
        chk("bb_gap", 64'(t0 - d1), 64'd2);
        bus.req = 1'b0;
        finish_req(-1);
        chk("bb2_lat", 64'(lat), 64'd16);
        chk("bb2_rdy", rdy_m, 64'h0);
        chk("bb2_data", 64'(bus.rdata), 64'h0BB0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/m68k_bus_master.md
# m68k_bus_master

Sequencer that turns a single-word request from the core-side glue into a 68000-style asynchronous bus cycle (S0–S7, with wait states) on the VA/VD/AS/UDS/LDS/RW bus. It sits directly upstream of the TMSS/bus-decode stage and drives the same strobes that stage decodes. It consumes that stage's DTACK and returns read data or a bus-error flag to the requester. Each state advances on an internal tick derived from MCLK, so the bus timing is cycle-exact and deterministic.

## Interface
Parameters:
- TICK_DIV, 2, MCLK cycles per bus state (≥1)
- TIMEOUT, 128, wait-state pairs before bus error (≥1)

Ports:
- MCLK  in  1  system clock; one clock, all logic on its rising edge
- RES_n  in  1  reset, asynchronous, active-low
- req  in  1  request valid; taken when req & req_ready
- req_rw  in  1  1 = read, 0 = write
- req_addr  in  23  word address, driven onto VA
- req_uds, req_lds  in  1 each  byte-lane enables, active-high
- req_wdata  in  16  write data
- req_ready  out  1  high only in IDLE
- done  out  1  one-MCLK pulse at cycle end
- berr  out  1  valid with done; 1 = timed out
- rdata  out  16  read result; held until next done
- VA  out  23  bus address
- AS, UDS, LDS  out  1 each  strobes, active-low
- RW  out  1  1 = read
- VD_o  out  16  write data
- VD_oe  out  1  write-data drive enable
- VD_i  in  16  read data
- DTACK  in  1  active-low acknowledge

## Operation
- Reset values: AS = UDS = LDS = RW = 1, VA = 0, VD_o = 0, VD_oe = 0, done = 0, berr = 0, rdata = 0, req_ready = 1. State is IDLE and the tick counter is 0.
- Tick: a free-running counter counts 0..TICK_DIV-1. tick = 1 when the count is TICK_DIV-1. The FSM changes state only on a tick.
- IDLE: on a tick with req = 1, latch addr, rw, uds, lds and wdata, then go to S0. req_ready drops in the same cycle.
- S0: drive VA and RW from the latched values.
- S1: no strobe change.
- S2: AS = 0. On a read, UDS/LDS = ~lane enables.
- S3: on a write, VD_o = wdata and VD_oe = 1.
- S4: on a write, UDS/LDS = ~lane enables. At the ending tick, sample DTACK through a 2-flop synchroniser:
  - DTACK low: go to S5.
  - DTACK high: insert a wait pair (W, W), then resample.
  - The wait-pair counter reaching TIMEOUT forces S5 with berr_pending set.
- S5: no strobe change.
- S6: at the ending tick, rdata = berr_pending ? 16'hFFFF : VD_i on a read. rdata is unchanged on a write.
- S7: AS = UDS = LDS = 1. At the ending tick:
  - done = 1 and berr = berr_pending.
  - VD_oe = 0, RW = 1.
  - Go to IDLE.
- req_ready returns 1 in the cycle after done. A new request can start at the next tick.
- Asserting RES_n mid-cycle immediately forces all reset values. No done is produced and the request is lost.
- The lane-enable inputs are not validated. uds = lds = 0 still runs the cycle with no data strobes.

## Timing
- Zero-wait cycle: 8 states = 8·TICK_DIV MCLK from the S0 tick to the done pulse.
- Each wait pair adds 2·TICK_DIV MCLK.
- DTACK must be low at least 2 MCLK before the S4-ending tick to be seen in that tick (synchroniser latency). A later assertion costs one wait pair.
- Timeout path: done arrives 3 ticks after the tick that forced S5.
- All outputs are registered and there are no combinational paths from the inputs.

## Structure
- Shared package m68k_bus_pkg holds:
  - state encoding: IDLE, S0–S7, W
  - strobe reset constants
  - rdata bus-error fill value 16'hFFFF
- One sub-module, bus_tick_gen: the TICK_DIV divider that outputs tick.

## Test plan
- TICK_DIV = 2, DTACK tied low, write 16'h5345 to 23'h50A000, then 16'h4741 to 23'h50A001. Required:
  - each done arrives 16 MCLK after its S0 tick, berr = 0
  - UDS/LDS low only during S4–S6
  - the downstream TMSS releases its reset.
- Read from 23'h000100 with VD_i = 16'h1234 and DTACK low. Required: rdata = 16'h1234 at done, VD_oe stays 0 throughout.
- DTACK released 3 wait pairs late on a read. Required: done arrives at 8·2 + 3·4 = 28 MCLK, berr = 0, AS held low through every W state.
- DTACK held high, TIMEOUT = 4. Required: done with berr = 1 and rdata = 16'hFFFF, and AS high at S7.
- RES_n pulsed low during S4 of a write. Required:
  - AS/UDS/LDS = 1 and VD_oe = 0 in the same cycle
  - no done
  - req_ready = 1 once RES_n rises.
- Back-to-back requests with req held high. Required: the second S0 starts at the first tick after done, and req_ready = 0 throughout each cycle.
